param_bank_mem: RTL and testbench

Parametrised, banked single-port RAM with self-initialisation, a synchronous clear, a ready handshake, per-lane write masking and a registered read response. It generalises the fixed-geometry memory wrappers in the audio datapath, such as the coefficient, data and register stores. Width, depth and bank count are set at instantiation. Storage is behavioural, one array per bank. After reset or clear, the block fills every word with `INIT_VAL` before it accepts traffic.

---
 rtl/param_bank_mem.sv | 84 ++++++++
 tb/tb_param_bank_mem.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/param_bank_mem.sv
// param_bank_mem: banked single-port RAM with self-initialisation, clear, ready handshake, lane masking and registered read
module param_bank_mem #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 512,
  parameter int BANKS    = 4,
  parameter int LANE_W   = 8,
  parameter int INIT_VAL = 0
) (
  input  logic                       RW0_clk,
  input  logic                       RW0_reset,
  input  logic                       RW0_clear,
  input  logic                       RW0_en,
  input  logic                       RW0_wmode,
  input  logic [$clog2(DEPTH)-1:0]   RW0_addr,
  input  logic [DATA_W-1:0]          RW0_wdata,
  input  logic [DATA_W/LANE_W-1:0]   RW0_wmask,
  output logic                       RW0_ready,
  output logic [DATA_W-1:0]          RW0_rdata,
  output logic                       RW0_rvalid
);
  localparam int AW   = $clog2(DEPTH);
  localparam int BW   = $clog2(BANKS);
  localparam int ROWS = DEPTH / BANKS;
  localparam int ML   = DATA_W / LANE_W;
  localparam int BWX  = BW > 0 ? BW : 1;
  localparam int RW   = (AW - BW) > 0 ? AW - BW : 1;
  typedef enum logic {INIT, IDLE} state_t;
  state_t          state_q, state_d;
  logic [RW-1:0]   cnt_q, cnt_d;
  logic            rvalid_q, rvalid_d;
  logic [BWX-1:0]  sel_q, sel_d;
  logic [BWX-1:0]  bank;
  logic [RW-1:0]   row;
  logic            wr, rd, init_wr;
  logic [DATA_W-1:0] bank_rd [BANKS];
  // state, fill counter, read-valid and registered bank select
  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      sel_q    <= sel_d;
    end
  end
  // clear restarts the fill; the last fill row hands over to IDLE
  always_comb begin
    state_d = RW0_clear ? INIT : (state_q == INIT && cnt_q == RW'(ROWS - 1)) ? IDLE : state_q;
    cnt_d   = RW0_clear ? '0 : (state_q == INIT) ? cnt_q + RW'(1) : cnt_q;
  end
  // request acceptance, address split and read bookkeeping
  always_comb begin
    bank      = BWX'(RW0_addr >> (AW - BW));
    row       = RW'(RW0_addr);
    RW0_ready = (state_q == IDLE) & ~RW0_clear & ~RW0_reset;
    wr        = RW0_en & RW0_ready & RW0_wmode;
    rd        = RW0_en & RW0_ready & ~RW0_wmode;
    init_wr   = (state_q == INIT) & ~RW0_clear & ~RW0_reset;
    rvalid_d  = rd;
    sel_d     = rd ? bank : sel_q;
  end
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [ROWS];
    logic [DATA_W-1:0] rd_q, rd_d;
    // fill row cnt during INIT, otherwise apply masked lane writes
    always_ff @(posedge RW0_clk) begin
      if (init_wr) mem[cnt_q] <= DATA_W'(INIT_VAL);
      else if (wr && bank == BWX'(b))
        for (int l = 0; l < ML; l++)
          if (RW0_wmask[l]) mem[row][l*LANE_W +: LANE_W] <= RW0_wdata[l*LANE_W +: LANE_W];
    end
    // read data only changes when this bank is read
    always_comb rd_d = (rd && bank == BWX'(b)) ? mem[row] : rd_q;
    // per-bank read register, zeroed only by reset
    always_ff @(posedge RW0_clk) rd_q <= RW0_reset ? '0 : rd_d;
    assign bank_rd[b] = rd_q;
  end
  assign RW0_rdata  = bank_rd[sel_q];
  assign RW0_rvalid = rvalid_q;
endmodule

// File: tb/tb_param_bank_mem.sv
// tb_param_bank_mem: table-driven and directed checks of param_bank_mem
module tb_param_bank_mem;
  logic clk = 1'b0;
  logic rst, clr, en, wm;
  logic [8:0]  addr;
  logic [15:0] wd;
  logic [1:0]  mk;
  logic        ready, rvalid;
  logic [15:0] rdata;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        wm;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic [1:0]  mk;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [21];
  always #5 clk = ~clk;
  param_bank_mem dut (
    .RW0_clk(clk), .RW0_reset(rst), .RW0_clear(clr), .RW0_en(en), .RW0_wmode(wm),
    .RW0_addr(addr), .RW0_wdata(wd), .RW0_wmask(mk),
    .RW0_ready(ready), .RW0_rdata(rdata), .RW0_rvalid(rvalid)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input string name, input int exp_n);
    int n = 0;
    while (ready !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk(name, n, exp_n);
  endtask
  task automatic req(input logic w, input logic [8:0] a, input logic [15:0] d, input logic [1:0] m);
    en = 1'b1; wm = w; addr = a; wd = d; mk = m;
    tick();
    en = 1'b0;
  endtask
  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; wm = 1'b0; addr = '0; wd = '0; mk = '0;
    vecs[0]  = '{1'b0, 9'h000, 16'h0000, 2'b00, 16'h0000};
    vecs[1]  = '{1'b0, 9'h07F, 16'h0000, 2'b00, 16'h0000};
    vecs[2]  = '{1'b0, 9'h080, 16'h0000, 2'b00, 16'h0000};
    vecs[3]  = '{1'b0, 9'h1FF, 16'h0000, 2'b00, 16'h0000};
    vecs[4]  = '{1'b1, 9'h1FF, 16'hA5C3, 2'b11, 16'h0000};
    vecs[5]  = '{1'b0, 9'h1FF, 16'h0000, 2'b00, 16'hA5C3};
    vecs[6]  = '{1'b1, 9'h1FF, 16'h1234, 2'b01, 16'hA5C3};
    vecs[7]  = '{1'b0, 9'h1FF, 16'h0000, 2'b00, 16'hA534};
    vecs[8]  = '{1'b1, 9'h1FF, 16'hFFFF, 2'b00, 16'hA534};
    vecs[9]  = '{1'b0, 9'h1FF, 16'h0000, 2'b00, 16'hA534};
    vecs[10] = '{1'b1, 9'h000, 16'h1111, 2'b11, 16'hA534};
    vecs[11] = '{1'b1, 9'h080, 16'h2222, 2'b11, 16'hA534};
    vecs[12] = '{1'b1, 9'h100, 16'h3333, 2'b11, 16'hA534};
    vecs[13] = '{1'b1, 9'h180, 16'h4444, 2'b11, 16'hA534};
    vecs[14] = '{1'b0, 9'h000, 16'h0000, 2'b00, 16'h1111};
    vecs[15] = '{1'b0, 9'h080, 16'h0000, 2'b00, 16'h2222};
    vecs[16] = '{1'b0, 9'h100, 16'h0000, 2'b00, 16'h3333};
    vecs[17] = '{1'b0, 9'h180, 16'h0000, 2'b00, 16'h4444};
    vecs[18] = '{1'b1, 9'h080, 16'hBEEF, 2'b10, 16'h4444};
    vecs[19] = '{1'b0, 9'h080, 16'h0000, 2'b00, 16'hBE22};
    vecs[20] = '{1'b0, 9'h001, 16'h0000, 2'b00, 16'h0000};
    repeat (3) tick();
    chk("reset_ready", ready, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_rvalid", rvalid, 0);
    rst = 1'b0;
    #1;
    chk("init_ready_low", ready, 0);
    wait_ready("init_latency", 128);
    for (int i = 0; i < 21; i++) begin
      en = 1'b1; wm = vecs[i].wm; addr = vecs[i].addr; wd = vecs[i].wd; mk = vecs[i].mk;
      #1;
      chk($sformatf("v%0d_ready", i), ready, 1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rvalid", i), rvalid, !vecs[i].wm);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp);
    end
    en = 1'b0;
    tick();
    chk("idle_rvalid_drop", rvalid, 0);
    chk("idle_rdata_hold", rdata, 16'h0000);
    req(1'b1, 9'h005, 16'h7777, 2'b11);
    en = 1'b1; wm = 1'b1; addr = 9'h005; wd = 16'hFFFF; mk = 2'b11; clr = 1'b1;
    #1;
    chk("clear_ready_drop", ready, 0);
    tick();
    clr = 1'b0; en = 1'b0;
    chk("clear_rdata_hold", rdata, 16'h0000);
    wait_ready("clear_latency", 128);
    req(1'b0, 9'h005, 16'h0000, 2'b00);
    chk("clear_rd_rvalid", rvalid, 1);
    chk("clear_rd_data", rdata, 16'h0000);
    req(1'b1, 9'h003, 16'hC0DE, 2'b11);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (60) tick();
    chk("init60_ready", ready, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_ready("init60_restart", 128);
    req(1'b1, 9'h003, 16'hC0DE, 2'b11);
    req(1'b0, 9'h003, 16'h0000, 2'b00);
    clr = 1'b1;
    #1;
    chk("pend_rvalid", rvalid, 1);
    chk("pend_rdata", rdata, 16'hC0DE);
    chk("pend_ready", ready, 0);
    tick();
    clr = 1'b0;
    chk("pend_rvalid_drop", rvalid, 0);
    chk("pend_rdata_hold", rdata, 16'hC0DE);
    wait_ready("clear2_latency", 128);
    chk("clear2_rdata_hold", rdata, 16'hC0DE);
    req(1'b0, 9'h003, 16'h0000, 2'b00);
    chk("clear2_rd_data", rdata, 16'h0000);
    req(1'b1, 9'h010, 16'h5A5A, 2'b11);
    req(1'b0, 9'h010, 16'h0000, 2'b00);
    chk("prerst_rdata", rdata, 16'h5A5A);
    rst = 1'b1;
    tick();
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 16'h0000);
    rst = 1'b0;
    for (int k = 0; k < 128; k++) begin
      en = 1'b1; wm = (k % 4) != 0; addr = 9'h011; wd = 16'hFFFF; mk = 2'b11;
      #1;
      chk($sformatf("initreq%0d_ready", k), ready, 0);
      @(posedge clk);
      #1;
      chk($sformatf("initreq%0d_rvalid", k), rvalid, 0);
    end
    en = 1'b0;
    #1;
    chk("initreq_done_ready", ready, 1);
    req(1'b0, 9'h011, 16'h0000, 2'b00);
    chk("initreq_rvalid", rvalid, 1);
    chk("initreq_nowrite", rdata, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
